// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU-to-BRAM port: RV32I load/store size codes and FSM encoding.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RESP      = 2'd2
   } lsuState_e;

   function automatic logic isLegal(input logic isStore, input logic [2:0] funct3);
      if (isStore)
         return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
             (funct3 == F3_BU) || (funct3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: picks the byte/halfword selected by the low address bits and extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   always_comb begin
      byteSel = rdata[{addr, 3'b000} +: 8];
      halfSel = addr[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    data = {{24{byteSel[7]}}, byteSel};
         F3_H:    data = {{16{halfSel[15]}}, halfSel};
         F3_W:    data = rdata;
         F3_BU:   data = {24'b0, byteSel};
         F3_HU:   data = {16'b0, halfSel};
         default: data = 32'b0;
      endcase
   end

endmodule

// File: rtl/lsu_bram_port.sv
// Single-outstanding LSU front end onto a read-first 32-bit BRAM port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating the address.
module lsu_bram_port
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   lsuState_e   state;
   logic [1:0]  addrQ;
   logic [2:0]  funct3Q;
   logic [31:0] loadData;

   logic        accept;
   logic        isHalf;
   logic        isWord;
   logic        trap;
   logic [1:0]  offset;
   logic        unusedAddrHi;

   assign req_ready    = rst_n && (state == IDLE);
   assign unusedAddrHi = ^req_addr[31:ADDR_WIDTH+2];

   always_comb begin
      accept = req_valid && req_ready;
      isHalf = (req_funct3[1:0] == 2'b01);
      isWord = (req_funct3[1:0] == 2'b10);
`ifdef LSU_MISALIGN_TRAP_EN
      trap   = !isLegal(req_we, req_funct3) ||
               (isHalf && req_addr[0]) || (isWord && (req_addr[1:0] != 2'b00));
      offset = req_addr[1:0];
`else
      // Misaligned halfword/word accesses silently round down to natural alignment.
      trap   = !isLegal(req_we, req_funct3);
      offset = isWord ? 2'b00 : (isHalf ? {req_addr[1], 1'b0} : req_addr[1:0]);
`endif
      mem_en    = 1'b0;
      mem_we    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = 32'b0;
      if (accept && !trap) begin
         mem_en   = 1'b1;
         mem_addr = req_addr[ADDR_WIDTH+1:2];
         if (req_we) begin
            case (req_funct3[1:0])
               2'b00: begin
                  mem_we    = 4'b0001 << offset;
                  mem_wdata = {4{req_wdata[7:0]}};
               end
               2'b01: begin
                  mem_we    = 4'b0011 << offset;
                  mem_wdata = {2{req_wdata[15:0]}};
               end
               default: begin
                  mem_we    = 4'b1111;
                  mem_wdata = req_wdata;
               end
            endcase
         end
      end
   end

   lsu_load_align uAlign (
      .rdata  (mem_rdata),
      .addr   (addrQ),
      .funct3 (funct3Q),
      .data   (loadData)
   );

   // state     | meaning
   // IDLE      | ready for a request; memory port driven in the accept cycle
   // LOAD_WAIT | BRAM read in flight; align and register the data at the edge
   // RESP      | rsp_valid high for exactly this cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'b0;
         rsp_err   <= 1'b0;
         addrQ     <= 2'b00;
         funct3Q   <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               rsp_valid <= 1'b0;
               if (accept) begin
                  if (trap || req_we) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= 32'b0;
                     rsp_err   <= trap;
                  end else begin
                     state   <= LOAD_WAIT;
                     addrQ   <= offset;
                     funct3Q <= req_funct3;
                  end
               end
            end
            LOAD_WAIT: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_rdata <= loadData;
               rsp_err   <= 1'b0;
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bram_port.sv
// Scoreboard bench for lsu_bram_port against a small read-first BRAM model.
module tb_lsu_bram_port;
   import lsu_pkg::*;

   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [2:0]    req_funct3 = 3'b000;
   logic [31:0]   req_addr = 32'b0;
   logic [31:0]   req_wdata = 32'b0;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = 32'b0;

   int nChecks = 0;
   int nFails  = 0;
   int cycleCnt = 0;

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   logic [31:0] memModel [16];

   always #5 clk = ~clk;

   lsu_bram_port #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Read-first BRAM model; reset reloads the known pattern in word 0.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) memModel[i] <= 32'b0;
         memModel[0] <= 32'h80FF7F01;
      end else if (mem_en) begin
         mem_rdata <= memModel[mem_addr[3:0]];
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) memModel[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cycleCnt);
         end else begin
            e = sb.pop_front();
            chk("rsp_cycle", cycleCnt, e.cyc);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
         end
      end
   end

   task automatic waitIdle(input string nm);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && req_ready) return;
      end
      nChecks++;
      nFails++;
      $display("FAIL %s_timeout: got no idle within 20 cycles expected idle", nm);
   endtask

   task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic expEn, input logic [3:0] expWe,
                        input logic [31:0] expMAddr, input logic [31:0] expWdata,
                        input int lat, input logic [31:0] expRd, input logic expErr);
      exp_t e;
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      chk({nm, "_ready"}, {31'b0, req_ready}, 32'd1);
      chk({nm, "_mem_en"}, {31'b0, mem_en}, {31'b0, expEn});
      chk({nm, "_mem_we"}, {28'b0, mem_we}, {28'b0, expWe});
      chk({nm, "_mem_addr"}, {19'b0, mem_addr}, expMAddr);
      chk({nm, "_mem_wdata"}, mem_wdata, expWdata);
      e.cyc = cycleCnt + lat; e.rdata = expRd; e.err = expErr;
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'b0; req_wdata = 32'b0;
      waitIdle(nm);
   endtask

   initial begin
      exp_t e;
      // Reset with a request presented: nothing may leak out.
      req_valid = 1'b1; req_funct3 = F3_W; req_addr = 32'h10;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      req_valid = 1'b0; req_funct3 = 3'b000; req_addr = 32'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

      issue("sw10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 32'd4, 32'hDEADBEEF, 1, 32'h0, 1'b0);
      issue("lw10", 1'b0, F3_W, 32'h10, 32'h0, 1'b1, 4'h0, 32'd4, 32'h0, 2, 32'hDEADBEEF, 1'b0);
      issue("lb2", 1'b0, F3_B, 32'h2, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 2, 32'hFFFFFFFF, 1'b0);
      repeat (3) @(negedge clk);
      chk("hold_rdata", rsp_rdata, 32'hFFFFFFFF);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd0);
      issue("lbu2", 1'b0, F3_BU, 32'h2, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 2, 32'h000000FF, 1'b0);
      issue("lb1", 1'b0, F3_B, 32'h1, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 2, 32'h0000007F, 1'b0);
      issue("lb3", 1'b0, F3_B, 32'h3, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 2, 32'hFFFFFF80, 1'b0);
      issue("lh2", 1'b0, F3_H, 32'h2, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 2, 32'hFFFF80FF, 1'b0);
      issue("lhu0", 1'b0, F3_HU, 32'h0, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 2, 32'h00007F01, 1'b0);
      issue("sh6", 1'b1, F3_H, 32'h6, 32'h0000ABCD, 1'b1, 4'hC, 32'd1, 32'hABCDABCD, 1, 32'h0, 1'b0);
      issue("lw4", 1'b0, F3_W, 32'h4, 32'h0, 1'b1, 4'h0, 32'd1, 32'h0, 2, 32'hABCD0000, 1'b0);
      issue("sb9", 1'b1, F3_B, 32'h9, 32'h12345677, 1'b1, 4'h2, 32'd2, 32'h77777777, 1, 32'h0, 1'b0);
      issue("lw8", 1'b0, F3_W, 32'h8, 32'h0, 1'b1, 4'h0, 32'd2, 32'h0, 2, 32'h00007700, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      issue("lw3", 1'b0, F3_W, 32'h3, 32'h0, 1'b0, 4'h0, 32'd0, 32'h0, 1, 32'h0, 1'b1);
      issue("lh3", 1'b0, F3_H, 32'h3, 32'h0, 1'b0, 4'h0, 32'd0, 32'h0, 1, 32'h0, 1'b1);
      issue("sh5", 1'b1, F3_H, 32'h5, 32'h1111BEEF, 1'b0, 4'h0, 32'd0, 32'h0, 1, 32'h0, 1'b1);
      issue("lw4b", 1'b0, F3_W, 32'h4, 32'h0, 1'b1, 4'h0, 32'd1, 32'h0, 2, 32'hABCD0000, 1'b0);
`else
      issue("lw3", 1'b0, F3_W, 32'h3, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 2, 32'h80FF7F01, 1'b0);
      issue("lh3", 1'b0, F3_H, 32'h3, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 2, 32'hFFFF80FF, 1'b0);
      issue("sh5", 1'b1, F3_H, 32'h5, 32'h1111BEEF, 1'b1, 4'h3, 32'd1, 32'hBEEFBEEF, 1, 32'h0, 1'b0);
      issue("lw4b", 1'b0, F3_W, 32'h4, 32'h0, 1'b1, 4'h0, 32'd1, 32'h0, 2, 32'hABCDBEEF, 1'b0);
`endif
      issue("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b0, 4'h0, 32'd0, 32'h0, 1, 32'h0, 1'b1);
      issue("lw10b", 1'b0, F3_W, 32'h10, 32'h0, 1'b1, 4'h0, 32'd4, 32'h0, 2, 32'hDEADBEEF, 1'b0);
      issue("st100", 1'b1, 3'b100, 32'h10, 32'h55, 1'b0, 4'h0, 32'd0, 32'h0, 1, 32'h0, 1'b1);

      // Back-to-back loads with req_valid held high.
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
      @(negedge clk);
      chk("b2b_ready_n", {31'b0, req_ready}, 32'd1);
      e.cyc = cycleCnt + 2; e.rdata = 32'hDEADBEEF; e.err = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      chk("b2b_ready_wait", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      chk("b2b_ready_resp", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      chk("b2b_ready_n3", {31'b0, req_ready}, 32'd1);
      e.cyc = cycleCnt + 2; e.rdata = 32'hDEADBEEF; e.err = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      waitIdle("b2b");

      // Reset while a load is in LOAD_WAIT: the response must be dropped.
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
      @(negedge clk);
      chk("rstlw_mem_en", {31'b0, mem_en}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rstlw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rstlw_rsp_rdata", rsp_rdata, 32'd0);
      chk("rstlw_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rstlw_ready", {31'b0, req_ready}, 32'd0);
      chk("rstlw_mem_en0", {31'b0, mem_en}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rstlw_quiet", {31'b0, rsp_valid}, 32'd0);
      issue("lb2_after", 1'b0, F3_B, 32'h2, 32'h0, 1'b1, 4'h0, 32'd0, 32'h0, 2, 32'hFFFFFFFF, 1'b0);

      repeat (2) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
